unary_add_n: RTL and testbench

UNARY_ADD_N -- requirements
Module: unary_add_n

---
 rtl/unary_add_n.sv | 82 ++++++++
 tb/tb_unary_add_n.sv | 125 ++++++++++++
 2 files changed

// File: rtl/unary_add_n.sv
// unary_add_n: modulo-MODULUS unary accumulator with serial unary drain.
//
// Optional feature macro: UNARY_ADD_CCNT_EN adds an 8-bit carry-pulse counter (ccnt).
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - synchronous active-high reset
//   en     - cycle enable; low holds state and zeroes the pulse outputs
//   mode   - 0 = accumulate, 1 = drain
//   din    - LANES unary pulses, each set bit adds one
//   dout   - serial unary output while draining
//   carry  - one-cycle pulse on modulus wrap
//   count  - registered accumulator value
//   done   - one-cycle pulse when a drain empties the accumulator
//   busy   - high while in DRAIN
//   ccnt   - carry pulses since reset, wraps at 256 (UNARY_ADD_CCNT_EN only)
module unary_add_n #(
    parameter int LANES = 4,
    parameter int MODULUS = 10,
    localparam int CW = $clog2(MODULUS + LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [LANES-1:0] din,
    output logic             dout,
    output logic             carry,
    output logic [CW-1:0]    count,
    output logic             done,
    output logic             busy
`ifdef UNARY_ADD_CCNT_EN
    ,
    output logic [7:0]       ccnt
`endif
);
    localparam logic [CW-1:0] MOD = CW'(MODULUS);
    typedef enum logic {ACC, DRAIN} state_t;
    state_t state;
    logic [CW-1:0] pc, sum;
    logic wrap;
    always_comb begin
        pc = '0;
        for (int i = 0; i < LANES; i++) pc = pc + CW'(din[i]);
        sum = count + pc;
        wrap = sum >= MOD;
    end
    assign busy = state == DRAIN;
    // Draining happens on the very edge that leaves ACC; the FSM stays in
    // DRAIN only while pulses remain after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            count <= '0;
            dout  <= 1'b0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (!en) begin
            dout  <= 1'b0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (!mode) begin
            state <= ACC;
            count <= wrap ? sum - MOD : sum;
            carry <= wrap;
            dout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= count > CW'(1) ? DRAIN : ACC;
            count <= count != '0 ? count - CW'(1) : count;
            dout  <= count != '0;
            done  <= count == CW'(1);
            carry <= 1'b0;
        end
    end
`ifdef UNARY_ADD_CCNT_EN
    always_ff @(posedge clk) begin
        if (rst) ccnt <= '0;
        else if (en && !mode && wrap) ccnt <= ccnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_unary_add_n.sv
// tb_unary_add_n: directed self-checking bench for unary_add_n at default parameters.
module tb_unary_add_n;
    logic clk = 1'b0;
    logic rst, en, mode, dout, carry, done, busy;
    logic [3:0] din;
    logic [3:0] count;
`ifdef UNARY_ADD_CCNT_EN
    logic [7:0] ccnt;
`endif
    int vectors = 0;
    int errors = 0;

    unary_add_n dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
        .dout(dout), .carry(carry), .count(count), .done(done), .busy(busy)
`ifdef UNARY_ADD_CCNT_EN
        , .ccnt(ccnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int d, input int cy, input int dn, input int b);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".dout"}, 32'(dout), 32'(d));
        chk({tag, ".carry"}, 32'(carry), 32'(cy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        int carries, m, cycles;
        rst = 1'b1; en = 1'b0; mode = 1'b0; din = 4'b0000;
        step(); step();
        rst = 1'b0;
        step();
        chk_all("reset", 0, 0, 0, 0, 0);

        en = 1'b1; din = 4'b1111;
        step(); chk_all("acc1", 4, 0, 0, 0, 0);
        step(); chk_all("acc2", 8, 0, 0, 0, 0);
        step(); chk_all("acc3_wrap", 2, 0, 1, 0, 0);
        din = 4'b0001;
        step(); chk_all("acc4", 3, 0, 0, 0, 0);

        mode = 1'b1; din = 4'b1111;
        step(); chk_all("drain1", 2, 1, 0, 0, 1);
        step(); chk_all("drain2", 1, 1, 0, 0, 1);
        step(); chk_all("drain3", 0, 1, 0, 1, 0);
        step(); chk_all("drain4", 0, 0, 0, 0, 0);
        step(); chk_all("drain5", 0, 0, 0, 0, 0);

        mode = 1'b0; din = 4'b0111;
        step(); chk_all("fill3", 3, 0, 0, 0, 0);
        din = 4'b1111;
        step(); chk_all("fill7", 7, 0, 0, 0, 0);
        mode = 1'b1; din = 4'b0000;
        step(); chk_all("part1", 6, 1, 0, 0, 1);
        step(); chk_all("part2", 5, 1, 0, 0, 1);
        mode = 1'b0; din = 4'b0011;
        step(); chk_all("resume", 7, 0, 0, 0, 0);

        mode = 1'b1; din = 4'b0000;
        step(); chk_all("pause_pre", 6, 1, 0, 0, 1);
        en = 1'b0;
        step(); chk_all("pause", 6, 0, 0, 0, 1);
        en = 1'b1;
        step(); chk_all("pause_post", 5, 1, 0, 0, 1);

        mode = 1'b0; din = 4'b1111;
        step(); chk_all("to9", 9, 0, 0, 0, 0);
        din = 4'b0001; rst = 1'b1;
        step(); chk_all("rst_wrap", 0, 0, 0, 0, 0);
        rst = 1'b0;

        din = 4'b1111;
        step(); step();
        din = 4'b0001;
        step(); chk_all("to9b", 9, 0, 0, 0, 0);
        step(); chk_all("exact_wrap", 0, 0, 1, 0, 0);

        din = 4'b0011;
        step();
        mode = 1'b1; rst = 1'b1;
        step(); chk_all("rst_drain", 0, 0, 0, 0, 0);
        rst = 1'b0; mode = 1'b0;

        din = 4'b1111; carries = 0; m = 0; cycles = 0;
        while (carries < 256 && cycles < 4000) begin
            step();
            cycles++;
            m = m + 4;
            if (m >= 10) begin
                m = m - 10;
                carries++;
                chk("wrap_carry", 32'(carry), 32'd1);
            end else begin
                chk("nowrap_carry", 32'(carry), 32'd0);
            end
            chk("wrap_count", 32'(count), 32'(m));
        end
        chk("wrap_bound", 32'(carries), 32'd256);
`ifdef UNARY_ADD_CCNT_EN
        chk("ccnt_wrap", 32'(ccnt), 32'd0);
`endif
        din = 4'b0000; en = 1'b0;
        step(); chk("idle_carry", 32'(carry), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
